// File: rtl/memhot_throttle_cond_pkg.sv
// Shared definitions for the MEMHOT_IN# throttle conditioning stage:
// FSM state encodings and sticky-status bit positions.
package memhot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam int unsigned ABCD = 0;
    localparam int unsigned EFGH = 1;
    localparam int unsigned THR  = 2;

endpackage

// File: rtl/memhot_throttle_cond_debounce.sv
// Two-flop synchronizer followed by a consecutive-stable-cycle debounce filter.
// The filtered output only moves after DEBOUNCE_CYC consecutive differing samples.
module memhot_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter logic        INACTIVE     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic force_inactive,
    input  logic async_in,
    output logic filtered
);

    localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYC - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= INACTIVE;
            sync2_q <= INACTIVE;
            filt_q  <= INACTIVE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample matching the filtered value drops the partial count (glitch discarded).
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (force_inactive) begin
            filt_d = INACTIVE;
        end else if (sync2_q != filt_q) begin
            if (cnt_q == LAST_CNT) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/memhot_throttle_cond.sv
// MEMHOT_IN# upstream conditioning: filters the VRHOT#/SYS_THROTTLE sources,
// stretches the combined request and keeps sticky status plus an event counter.
module memhot_throttle_cond
    import memhot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = 4,
    parameter int unsigned MIN_ASSERT_CYC = 2000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             PWRGD_SYS_PWROK,
    input  logic             IRQ_PVDDQ_ABCD_VRHOT_LVC3_N,
    input  logic             IRQ_PVDDQ_EFGH_VRHOT_LVC3_N,
    input  logic             FM_SYS_THROTTLE_LVC3,
    input  logic             iClrStatus,
    output logic             oVrhotAbcd_n,
    output logic             oVrhotEfgh_n,
    output logic             oSysThrottle,
    output logic             oThrottleReq,
    output logic [2:0]       oStatus,
    output logic [CNT_W-1:0] oEvtCnt
);

    localparam int unsigned        HOLD_W   = 16;
    localparam logic [HOLD_W-1:0]  MIN_HOLD = HOLD_W'(MIN_ASSERT_CYC);

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
    logic               req_q, req_d;
    logic [2:0]         status_q, status_d, status_set;
    logic [CNT_W-1:0]   evt_q, evt_d;
    logic               evt_inc;
    logic               act;
    logic               force_idle;

    assign force_idle = !PWRGD_SYS_PWROK;

    memhot_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INACTIVE(1'b1)) u_deb_abcd (
        .clk(iClk), .rst_n(iRst_n), .force_inactive(force_idle),
        .async_in(IRQ_PVDDQ_ABCD_VRHOT_LVC3_N), .filtered(oVrhotAbcd_n)
    );

    memhot_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INACTIVE(1'b1)) u_deb_efgh (
        .clk(iClk), .rst_n(iRst_n), .force_inactive(force_idle),
        .async_in(IRQ_PVDDQ_EFGH_VRHOT_LVC3_N), .filtered(oVrhotEfgh_n)
    );

    memhot_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .INACTIVE(1'b0)) u_deb_thr (
        .clk(iClk), .rst_n(iRst_n), .force_inactive(force_idle),
        .async_in(FM_SYS_THROTTLE_LVC3), .filtered(oSysThrottle)
    );

    assign act = PWRGD_SYS_PWROK & (!oVrhotAbcd_n | !oVrhotEfgh_n | oSysThrottle);

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            req_q    <= 1'b0;
            status_q <= '0;
            evt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            req_q    <= req_d;
            status_q <= status_d;
            evt_q    <= evt_d;
        end
    end

    assign hold_inc = (hold_q >= MIN_HOLD) ? MIN_HOLD : hold_q + HOLD_W'(1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        evt_inc = 1'b0;
        if (!PWRGD_SYS_PWROK) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (act) begin
                        state_d = ST_ASSERT;
                        hold_d  = HOLD_W'(1);
                        evt_inc = 1'b1;
                    end
                end
                ST_ASSERT: begin
                    hold_d = hold_inc;
                    if (!act) begin
                        state_d = (hold_q >= MIN_HOLD) ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    hold_d = hold_inc;
                    if (act) begin
                        state_d = ST_ASSERT;
                    end else if (hold_q >= MIN_HOLD) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
        req_d = (state_d != ST_IDLE);
    end

    // A set in the same cycle as a clear survives; the counter restarts at the new event.
    always_comb begin
        status_set       = '0;
        status_set[ABCD] = PWRGD_SYS_PWROK & !oVrhotAbcd_n;
        status_set[EFGH] = PWRGD_SYS_PWROK & !oVrhotEfgh_n;
        status_set[THR]  = PWRGD_SYS_PWROK & oSysThrottle;
        status_d = (iClrStatus ? 3'b000 : status_q) | status_set;

        evt_d = evt_q;
        if (iClrStatus) begin
            evt_d = {{(CNT_W-1){1'b0}}, evt_inc};
        end else if (evt_inc && (evt_q != '1)) begin
            evt_d = evt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign oThrottleReq = req_q;
    assign oStatus      = status_q;
    assign oEvtCnt      = evt_q;

endmodule

// File: tb/tb_memhot_throttle_cond.sv
// Bench for memhot_throttle_cond: directed scenarios plus randomized stimulus
// compared against an event-level model of source activity and request timing.
module tb_memhot_throttle_cond;

    localparam int unsigned D   = 4;
    localparam int unsigned MIN = 20;
    localparam int unsigned CW  = 2;

    logic          iClk;
    logic          iRst_n;
    logic          pwrok;
    logic          abcd_n;
    logic          efgh_n;
    logic          thr;
    logic          clr;
    logic          oVrhotAbcd_n;
    logic          oVrhotEfgh_n;
    logic          oSysThrottle;
    logic          oThrottleReq;
    logic [2:0]    oStatus;
    logic [CW-1:0] oEvtCnt;

    int total;
    int bad;

    memhot_throttle_cond #(
        .DEBOUNCE_CYC(D),
        .MIN_ASSERT_CYC(MIN),
        .CNT_W(CW)
    ) dut (
        .iClk(iClk),
        .iRst_n(iRst_n),
        .PWRGD_SYS_PWROK(pwrok),
        .IRQ_PVDDQ_ABCD_VRHOT_LVC3_N(abcd_n),
        .IRQ_PVDDQ_EFGH_VRHOT_LVC3_N(efgh_n),
        .FM_SYS_THROTTLE_LVC3(thr),
        .iClrStatus(clr),
        .oVrhotAbcd_n(oVrhotAbcd_n),
        .oVrhotEfgh_n(oVrhotEfgh_n),
        .oSysThrottle(oSysThrottle),
        .oThrottleReq(oThrottleReq),
        .oStatus(oStatus),
        .oEvtCnt(oEvtCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Model state, all in "source active" polarity: bit0 ABCD, bit1 EFGH, bit2 throttle.
    logic [2:0] m_s1, m_s2, m_fact, m_stat;
    int         m_since [3];
    logic       m_req;
    int         m_rise;
    int         m_evt;
    int         cyc;

    initial begin
        cyc = 0;
        m_s1 = '0; m_s2 = '0; m_fact = '0; m_stat = '0;
        m_req = 1'b0; m_rise = 0; m_evt = 0;
        for (int i = 0; i < 3; i++) m_since[i] = -1;
    end

    always @(posedge iClk) begin : model
        logic [2:0] s2_old, fa_old, ain;
        logic       act, inc;
        cyc++;
        ain = {thr, ~efgh_n, ~abcd_n};
        if (!iRst_n) begin
            m_s1 = '0; m_s2 = '0; m_fact = '0; m_stat = '0;
            m_req = 1'b0; m_evt = 0;
            for (int i = 0; i < 3; i++) m_since[i] = -1;
        end else begin
            s2_old = m_s2;
            fa_old = m_fact;
            m_s2 = m_s1;
            m_s1 = ain;
            act = pwrok && (fa_old != 3'b000);
            for (int i = 0; i < 3; i++) begin
                if (!pwrok) begin
                    m_fact[i] = 1'b0;
                    m_since[i] = -1;
                end else if (s2_old[i] == fa_old[i]) begin
                    m_since[i] = -1;
                end else begin
                    if (m_since[i] < 0) m_since[i] = cyc;
                    if (cyc - m_since[i] + 1 >= int'(D)) begin
                        m_fact[i] = s2_old[i];
                        m_since[i] = -1;
                    end
                end
            end
            inc = 1'b0;
            if (!pwrok) begin
                m_req = 1'b0;
            end else if (!m_req) begin
                if (act) begin
                    m_req = 1'b1;
                    m_rise = cyc;
                    inc = 1'b1;
                end
            end else if (!act && (cyc - m_rise >= int'(MIN))) begin
                m_req = 1'b0;
            end
            m_stat = (clr ? 3'b000 : m_stat) | (pwrok ? fa_old : 3'b000);
            if (clr) m_evt = inc ? 1 : 0;
            else if (inc && m_evt < (1 << CW) - 1) m_evt++;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge iClk);
    endtask

    task automatic test_reset;
        iRst_n = 1'b0; pwrok = 1'b1; abcd_n = 1'b1; efgh_n = 1'b1; thr = 1'b0; clr = 1'b0;
        tick(3);
        total++;
        if ({oVrhotAbcd_n, oVrhotEfgh_n, oSysThrottle, oThrottleReq, oStatus, oEvtCnt} !== 9'b110_0_000_00) begin
            bad++;
            $display("FAIL reset_values got=%b %b %b %b %b %b want=1 1 0 0 000 00",
                     oVrhotAbcd_n, oVrhotEfgh_n, oSysThrottle, oThrottleReq, oStatus, oEvtCnt);
        end
        iRst_n = 1'b1;
        tick(4);
        total++;
        if (oThrottleReq !== 1'b0 || oStatus !== 3'b000) begin
            bad++;
            $display("FAIL reset_release got req=%b status=%b want req=0 status=000", oThrottleReq, oStatus);
        end
    endtask

    task automatic test_glitch;
        abcd_n = 1'b0;
        tick(3);
        abcd_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            total++;
            if (oVrhotAbcd_n !== 1'b1 || oThrottleReq !== 1'b0) begin
                bad++;
                $display("FAIL glitch_reject cyc=%0d got filt=%b req=%b want filt=1 req=0", i, oVrhotAbcd_n, oThrottleReq);
            end
        end
        total++;
        if (oStatus !== 3'b000) begin
            bad++;
            $display("FAIL glitch_status got=%b want=000", oStatus);
        end
    endtask

    task automatic test_assert_latency;
        int w;
        abcd_n = 1'b0;
        tick(5);
        total++;
        if (oVrhotAbcd_n !== 1'b1) begin
            bad++;
            $display("FAIL latency_filt_early got=%b want=1", oVrhotAbcd_n);
        end
        tick(1);
        total++;
        if (oVrhotAbcd_n !== 1'b0 || oThrottleReq !== 1'b0) begin
            bad++;
            $display("FAIL latency_filt_6 got filt=%b req=%b want filt=0 req=0", oVrhotAbcd_n, oThrottleReq);
        end
        tick(1);
        total++;
        if (oThrottleReq !== 1'b1 || oEvtCnt !== 2'd1 || oStatus !== 3'b001) begin
            bad++;
            $display("FAIL latency_req_7 got req=%b evt=%0d status=%b want req=1 evt=1 status=001",
                     oThrottleReq, oEvtCnt, oStatus);
        end
        abcd_n = 1'b1;
        w = 0;
        while (oThrottleReq !== 1'b0 && w < 60) begin tick(1); w++; end
        total++;
        if (oThrottleReq !== 1'b0) begin
            bad++;
            $display("FAIL latency_release_timeout got req=%b want=0", oThrottleReq);
        end
        tick(2);
    endtask

    task automatic test_min_stretch;
        int cnt;
        int w;
        clr = 1'b1; tick(1); clr = 1'b0;
        total++;
        if (oEvtCnt !== 2'd0 || oStatus !== 3'b000) begin
            bad++;
            $display("FAIL stretch_clear got evt=%0d status=%b want evt=0 status=000", oEvtCnt, oStatus);
        end
        thr = 1'b1;
        tick(6);
        total++;
        if (oSysThrottle !== 1'b1) begin
            bad++;
            $display("FAIL stretch_filt got=%b want=1", oSysThrottle);
        end
        tick(1);
        cnt = (oThrottleReq === 1'b1) ? 1 : 0;
        tick(1);
        if (oThrottleReq === 1'b1) cnt++;
        thr = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (oThrottleReq !== 1'b1) break;
            cnt++;
        end
        total++;
        if (cnt !== int'(MIN)) begin
            bad++;
            $display("FAIL stretch_width got=%0d cycles want=%0d", cnt, MIN);
        end
        total++;
        if (oEvtCnt !== 2'd1) begin
            bad++;
            $display("FAIL stretch_evt got=%0d want=1", oEvtCnt);
        end
        // Re-assert while the stretch is still running.
        thr = 1'b1;
        tick(7);
        total++;
        if (oThrottleReq !== 1'b1 || oEvtCnt !== 2'd2) begin
            bad++;
            $display("FAIL reassert_rise got req=%b evt=%0d want req=1 evt=2", oThrottleReq, oEvtCnt);
        end
        tick(1);
        thr = 1'b0;
        tick(8);
        thr = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            total++;
            if (oThrottleReq !== 1'b1 || oEvtCnt !== 2'd2) begin
                bad++;
                $display("FAIL reassert_hold cyc=%0d got req=%b evt=%0d want req=1 evt=2", i, oThrottleReq, oEvtCnt);
            end
        end
        thr = 1'b0;
        w = 0;
        while (oThrottleReq !== 1'b0 && w < 60) begin tick(1); w++; end
        total++;
        if (oThrottleReq !== 1'b0 || oEvtCnt !== 2'd2) begin
            bad++;
            $display("FAIL reassert_release got req=%b evt=%0d want req=0 evt=2", oThrottleReq, oEvtCnt);
        end
        tick(2);
    endtask

    task automatic test_pwrok_drop;
        clr = 1'b1; tick(1); clr = 1'b0;
        abcd_n = 1'b0; efgh_n = 1'b0;
        tick(8);
        total++;
        if (oThrottleReq !== 1'b1 || oVrhotAbcd_n !== 1'b0 || oVrhotEfgh_n !== 1'b0 || oStatus !== 3'b011) begin
            bad++;
            $display("FAIL pwrok_pre got req=%b a=%b e=%b status=%b want req=1 a=0 e=0 status=011",
                     oThrottleReq, oVrhotAbcd_n, oVrhotEfgh_n, oStatus);
        end
        pwrok = 1'b0;
        tick(1);
        total++;
        if (oThrottleReq !== 1'b0 || oVrhotAbcd_n !== 1'b1 || oVrhotEfgh_n !== 1'b1 ||
            oSysThrottle !== 1'b0 || oStatus !== 3'b011) begin
            bad++;
            $display("FAIL pwrok_drop got req=%b a=%b e=%b t=%b status=%b want req=0 a=1 e=1 t=0 status=011",
                     oThrottleReq, oVrhotAbcd_n, oVrhotEfgh_n, oSysThrottle, oStatus);
        end
        abcd_n = 1'b1; efgh_n = 1'b1;
        tick(4);
        pwrok = 1'b1;
        tick(3);
        total++;
        if (oThrottleReq !== 1'b0 || oStatus !== 3'b011) begin
            bad++;
            $display("FAIL pwrok_restore got req=%b status=%b want req=0 status=011", oThrottleReq, oStatus);
        end
    endtask

    task automatic test_saturation_clear;
        int w;
        clr = 1'b1; tick(1); clr = 1'b0;
        total++;
        if (oEvtCnt !== 2'd0) begin
            bad++;
            $display("FAIL sat_clear got=%0d want=0", oEvtCnt);
        end
        for (int e = 0; e < 5; e++) begin
            efgh_n = 1'b0;
            tick(8);
            efgh_n = 1'b1;
            w = 0;
            while (oThrottleReq !== 1'b0 && w < 60) begin tick(1); w++; end
            total++;
            if (oThrottleReq !== 1'b0) begin
                bad++;
                $display("FAIL sat_event_timeout event=%0d got req=%b want=0", e, oThrottleReq);
            end
            tick(2);
        end
        total++;
        if (oEvtCnt !== 2'd3 || oStatus !== 3'b010) begin
            bad++;
            $display("FAIL sat_count got evt=%0d status=%b want evt=3 status=010", oEvtCnt, oStatus);
        end
        abcd_n = 1'b0;
        tick(6);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        total++;
        if (oEvtCnt !== 2'd1 || oThrottleReq !== 1'b1 || oStatus !== 3'b001) begin
            bad++;
            $display("FAIL clr_coincident got evt=%0d req=%b status=%b want evt=1 req=1 status=001",
                     oEvtCnt, oThrottleReq, oStatus);
        end
        abcd_n = 1'b1;
        w = 0;
        while (oThrottleReq !== 1'b0 && w < 60) begin tick(1); w++; end
        total++;
        if (oThrottleReq !== 1'b0) begin
            bad++;
            $display("FAIL clr_release_timeout got req=%b want=0", oThrottleReq);
        end
        tick(2);
    endtask

    task automatic test_reset_mid_hold;
        abcd_n = 1'b0;
        tick(8);
        abcd_n = 1'b1;
        tick(9);
        total++;
        if (oThrottleReq !== 1'b1 || oVrhotAbcd_n !== 1'b1) begin
            bad++;
            $display("FAIL hold_entry got req=%b filt=%b want req=1 filt=1", oThrottleReq, oVrhotAbcd_n);
        end
        iRst_n = 1'b0;
        tick(1);
        iRst_n = 1'b1;
        total++;
        if ({oVrhotAbcd_n, oVrhotEfgh_n, oSysThrottle, oThrottleReq, oStatus, oEvtCnt} !== 9'b110_0_000_00) begin
            bad++;
            $display("FAIL reset_mid_hold got=%b %b %b %b %b %b want=1 1 0 0 000 00",
                     oVrhotAbcd_n, oVrhotEfgh_n, oSysThrottle, oThrottleReq, oStatus, oEvtCnt);
        end
        tick(3);
        total++;
        if (oThrottleReq !== 1'b0 || oEvtCnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid_hold_idle got req=%b evt=%0d want req=0 evt=0", oThrottleReq, oEvtCnt);
        end
    endtask

    task automatic test_random;
        logic [8:0] got, want;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            got  = {oVrhotAbcd_n, oVrhotEfgh_n, oSysThrottle, oThrottleReq, oStatus, oEvtCnt};
            want = {~m_fact[0], ~m_fact[1], m_fact[2], m_req, m_stat, m_evt[CW-1:0]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, got, want);
            end
            if ($urandom_range(0, 11) == 0) abcd_n = ~abcd_n;
            if ($urandom_range(0, 13) == 0) efgh_n = ~efgh_n;
            if ($urandom_range(0, 9) == 0)  thr = ~thr;
            if (pwrok && $urandom_range(0, 399) == 0) pwrok = 1'b0;
            else if (!pwrok && $urandom_range(0, 19) == 0) pwrok = 1'b1;
            clr = ($urandom_range(0, 39) == 0);
            iRst_n = ($urandom_range(0, 1499) != 0);
        end
        iRst_n = 1'b1;
        clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        iRst_n = 1'b0; pwrok = 1'b1; abcd_n = 1'b1; efgh_n = 1'b1; thr = 1'b0; clr = 1'b0;
        test_reset;
        test_glitch;
        test_assert_latency;
        test_min_stretch;
        test_pwrok_drop;
        test_saturation_clear;
        test_reset_mid_hold;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
